alu_share_arb: RTL and testbench



---
 rtl/alu_share_arb.sv | 156 +++++++++++++++
 tb/tb_alu_share_arb.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Two-client arbiter time-sharing one combinational 32-bit ALU, with an
// in-order response FIFO tagged by requester index.

package definitions;
    typedef enum logic [2:0] {
        ALU_OR  = 3'd0,
        ALU_AND = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd3
    } alu_operation;
endpackage

module alu
    import definitions::*;
(
    input  logic [31:0]  rs_i,
    input  logic [31:0]  rt_i,
    input  alu_operation op_i,
    output logic [31:0]  result_o,
    output logic         zero_o
);
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_OR:  result_o = rs_i | rt_i;
            ALU_AND: result_o = rs_i & rt_i;
            ALU_ADD: result_o = rs_i + rt_i;
            ALU_SUB: result_o = rs_i - rt_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == 32'd0);
endmodule

module alu_share_arb
    import definitions::*;
#(
    parameter int RSP_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [31:0]  req0_rs_i,
    input  logic [31:0]  req0_rt_i,
    input  alu_operation req0_op_i,

    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [31:0]  req1_rs_i,
    input  logic [31:0]  req1_rt_i,
    input  alu_operation req1_op_i,

    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic [31:0]  rsp_result_o,
    output logic         rsp_zero_o,
    output logic         busy_o
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int ENT_W = 34;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(RSP_DEPTH - 1);

    logic                rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [ENT_W-1:0]    mem_q [RSP_DEPTH];

    logic                pop;
    logic                space;
    logic                gnt0, gnt1;
    logic                push;
    logic                gnt_id;
    logic [31:0]         alu_rs, alu_rt, alu_result;
    alu_operation        alu_op;
    logic                alu_zero;

    assign rsp_valid_o = (count_q != '0);
    assign busy_o      = rsp_valid_o;
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign space       = (count_q < DEPTH_C) | pop;

    // Grants are held low while reset is asserted so nothing is accepted then.
    assign gnt0 = rst_n & space & req0_valid_i & (~req1_valid_i | ~rr_ptr_q);
    assign gnt1 = rst_n & space & req1_valid_i & (~req0_valid_i |  rr_ptr_q);
    assign push   = gnt0 | gnt1;
    assign gnt_id = gnt1;

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    assign alu_rs = gnt1 ? req1_rs_i : req0_rs_i;
    assign alu_rt = gnt1 ? req1_rt_i : req0_rt_i;
    assign alu_op = gnt1 ? req1_op_i : req0_op_i;

    alu u_alu (
        .rs_i     (alu_rs),
        .rt_i     (alu_rt),
        .op_i     (alu_op),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            rr_ptr_d = ~gnt_id;
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head fields read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {gnt_id, alu_result, alu_zero};
        end
    end

    assign {rsp_id_o, rsp_result_o, rsp_zero_o} = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: transfers push expected responses,
// consumer pops are compared in order; scenario tasks add inline checks.
module tb_alu_share_arb;
    import definitions::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic         req0_ready_o, req1_ready_o;
    logic [31:0]  req0_rs_i = '0, req0_rt_i = '0, req1_rs_i = '0, req1_rt_i = '0;
    alu_operation req0_op_i = ALU_OR, req1_op_i = ALU_OR;
    logic         rsp_valid_o, rsp_ready_i = 1'b0, rsp_id_o, rsp_zero_o, busy_o;
    logic [31:0]  rsp_result_o;

    always #5 clk = ~clk;

    alu_share_arb #(.RSP_DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_rs_i    (req0_rs_i),
        .req0_rt_i    (req0_rt_i),
        .req0_op_i    (req0_op_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_rs_i    (req1_rs_i),
        .req1_rt_i    (req1_rt_i),
        .req1_op_i    (req1_op_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_zero_o   (rsp_zero_o),
        .busy_o       (busy_o)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        z;
    } rsp_t;

    rsp_t        sb_q[$];
    rsp_t        sb_exp;
    logic [32:0] mres;
    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    logic        m_rr = 1'b0;

    function automatic logic [32:0] model(input alu_operation op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_OR:  r = a | b;
            ALU_AND: r = a & b;
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            default: r = 32'd0;
        endcase
        return {r, (r == 32'd0)};
    endfunction

    // Scoreboard: pop before push so a same-cycle pop sees the older entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid_o && rsp_ready_i) begin
                pops++;
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: got id=%0d result=%h zero=%0d, required no response",
                             rsp_id_o, rsp_result_o, rsp_zero_o);
                end else begin
                    sb_exp = sb_q.pop_front();
                    if ({rsp_id_o, rsp_result_o, rsp_zero_o} !== sb_exp) begin
                        bad++;
                        $display("FAIL rsp_order: got id=%0d result=%h zero=%0d, required id=%0d result=%h zero=%0d",
                                 rsp_id_o, rsp_result_o, rsp_zero_o, sb_exp.id, sb_exp.res, sb_exp.z);
                    end
                end
            end
            if (req0_valid_i && req0_ready_o) begin
                mres = model(req0_op_i, req0_rs_i, req0_rt_i);
                sb_q.push_back({1'b0, mres});
                m_rr = 1'b1;
            end
            if (req1_valid_i && req1_ready_o) begin
                mres = model(req1_op_i, req1_rs_i, req1_rt_i);
                sb_q.push_back({1'b1, mres});
                m_rr = 1'b0;
            end
        end
    end

    task automatic drive(input bit n, input alu_operation op, input logic [31:0] a, input logic [31:0] b);
        if (n == 1'b0) begin
            req0_valid_i = 1'b1; req0_op_i = op; req0_rs_i = a; req0_rt_i = b;
        end else begin
            req1_valid_i = 1'b1; req1_op_i = op; req1_rs_i = a; req1_rt_i = b;
        end
    endtask

    task automatic issue(input bit n, input alu_operation op, input logic [31:0] a, input logic [31:0] b);
        bit done = 1'b0;
        drive(n, op, a, b);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((n == 1'b0) ? req0_ready_o : req1_ready_o) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL issue_timeout: requester %0d got no grant in 40 cycles, required a grant", n);
        end
        @(posedge clk);
        #1;
        if (n == 1'b0) req0_valid_i = 1'b0; else req1_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy_o) done = 1'b1;
        end
        total++;
        if (!done || sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: busy=%0d left=%0d, required busy=0 left=0", busy_o, sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        repeat (2) begin
            #2;
            total++;
            if ({req0_ready_o, req1_ready_o, rsp_valid_o, busy_o, rsp_id_o, rsp_zero_o} !== 6'b0 ||
                rsp_result_o !== 32'd0) begin
                bad++;
                $display("FAIL reset_state: got rdy=%b%b valid=%0d busy=%0d id=%0d result=%h zero=%0d, required all 0",
                         req0_ready_o, req1_ready_o, rsp_valid_o, busy_o, rsp_id_o, rsp_result_o, rsp_zero_o);
            end
            @(posedge clk);
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        rsp_ready_i = 1'b0;
        drive(1'b0, ALU_ADD, 32'd5, 32'd3);
        @(negedge clk);
        total++;
        if (req0_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL single_ready: got %0d, required 1", req0_ready_o);
        end
        @(posedge clk);
        #1;
        req0_valid_i = 1'b0;
        total++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o} !== {1'b1, 1'b0, 32'd8, 1'b0}) begin
            bad++;
            $display("FAIL single_rsp: got valid=%0d id=%0d result=%h zero=%0d, required 1 0 00000008 0",
                     rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o);
        end
        drain();
    endtask

    task automatic test_wrap_zero();
        rsp_ready_i = 1'b1;
        issue(1'b1, ALU_SUB, 32'd0, 32'd1);
        total++;
        if (rsp_result_o !== 32'hFFFF_FFFF || rsp_zero_o !== 1'b0) begin
            bad++;
            $display("FAIL sub_wrap: got result=%h zero=%0d, required ffffffff 0", rsp_result_o, rsp_zero_o);
        end
        issue(1'b1, ALU_SUB, 32'd7, 32'd7);
        total++;
        if (rsp_result_o !== 32'd0 || rsp_zero_o !== 1'b1) begin
            bad++;
            $display("FAIL sub_zero: got result=%h zero=%0d, required 00000000 1", rsp_result_o, rsp_zero_o);
        end
        issue(1'b0, ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        issue(1'b0, ALU_OR, 32'h1234_0000, 32'h0000_5678);
        issue(1'b1, alu_operation'(3'd6), 32'd5, 32'd9);
        total++;
        if (rsp_result_o !== 32'd0 || rsp_zero_o !== 1'b1) begin
            bad++;
            $display("FAIL undef_op: got result=%h zero=%0d, required 00000000 1", rsp_result_o, rsp_zero_o);
        end
        drain();
    endtask

    task automatic test_contention();
        logic e;
        int   p0;
        e  = m_rr;
        p0 = pops;
        rsp_ready_i = 1'b1;
        drive(1'b0, ALU_ADD, 32'h100, 32'h1);
        drive(1'b1, ALU_SUB, 32'h50, 32'h8);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (req0_ready_o !== (e == 1'b0) || req1_ready_o !== (e == 1'b1)) begin
                bad++;
                $display("FAIL contention_grant: cycle %0d got rdy0=%0d rdy1=%0d, required grant to %0d",
                         i, req0_ready_o, req1_ready_o, e);
            end
            if (i > 0) begin
                total++;
                if (rsp_valid_o !== 1'b1) begin
                    bad++;
                    $display("FAIL contention_rate: cycle %0d got rsp_valid=%0d, required 1", i, rsp_valid_o);
                end
            end
            e = ~e;
        end
        @(posedge clk);
        #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        drain();
        total++;
        if (pops - p0 !== 6) begin
            bad++;
            $display("FAIL contention_count: got %0d responses, required 6", pops - p0);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready_i = 1'b0;
        issue(1'b0, ALU_OR, 32'hF0, 32'h0F);
        issue(1'b0, ALU_AND, 32'hFF, 32'h0F);
        drive(1'b0, ALU_ADD, 32'd2, 32'd2);
        repeat (3) begin
            @(negedge clk);
            total++;
            if (req0_ready_o !== 1'b0 || busy_o !== 1'b1 || rsp_result_o !== 32'hFF) begin
                bad++;
                $display("FAIL bp_hold: got rdy=%0d busy=%0d result=%h, required 0 1 000000ff",
                         req0_ready_o, busy_o, rsp_result_o);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (req0_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_resume: got rdy=%0d, required 1 in the first pop cycle", req0_ready_o);
        end
        @(posedge clk);
        #1;
        req0_valid_i = 1'b0;
        drain();
    endtask

    task automatic test_full_pop_push();
        rsp_ready_i = 1'b0;
        issue(1'b0, ALU_ADD, 32'd1, 32'd2);
        issue(1'b0, ALU_ADD, 32'd3, 32'd4);
        drive(1'b1, ALU_OR, 32'h10, 32'h01);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (req1_ready_o !== 1'b1 || rsp_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL full_swap: got rdy1=%0d valid=%0d, required 1 1", req1_ready_o, rsp_valid_o);
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        drive(1'b1, ALU_AND, 32'hF, 32'h3);
        @(negedge clk);
        total++;
        if (req1_ready_o !== 1'b0 || busy_o !== 1'b1 || rsp_result_o !== 32'd7) begin
            bad++;
            $display("FAIL full_still: got rdy1=%0d busy=%0d head=%h, required 0 1 00000007",
                     req1_ready_o, busy_o, rsp_result_o);
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (req1_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL full_resume: got rdy1=%0d, required 1", req1_ready_o);
        end
        @(posedge clk);
        #1;
        req1_valid_i = 1'b0;
        drain();
    endtask

    task automatic test_async_reset();
        rsp_ready_i = 1'b0;
        issue(1'b1, ALU_OR, 32'hA5, 32'h5A0);
        issue(1'b1, ALU_ADD, 32'd9, 32'd9);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rsp_valid_o, busy_o, rsp_id_o, rsp_zero_o} !== 4'b0 || rsp_result_o !== 32'd0) begin
            bad++;
            $display("FAIL async_clear: got valid=%0d busy=%0d id=%0d result=%h zero=%0d, required all 0",
                     rsp_valid_o, busy_o, rsp_id_o, rsp_result_o, rsp_zero_o);
        end
        sb_q.delete();
        m_rr = 1'b0;
        drive(1'b0, ALU_ADD, 32'd20, 32'd22);
        drive(1'b1, ALU_SUB, 32'd30, 32'd1);
        #1;
        total++;
        if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got rdy0=%0d rdy1=%0d, required 0 0", req0_ready_o, req1_ready_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_first: got rdy0=%0d rdy1=%0d, required 1 0", req0_ready_o, req1_ready_o);
        end
        @(posedge clk);
        #1;
        req0_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if (req1_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_second: got rdy1=%0d, required 1", req1_ready_o);
        end
        @(posedge clk);
        #1;
        req1_valid_i = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_wrap_zero();
        test_contention();
        test_backpressure();
        test_full_pop_push();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
